// File: rtl/mem_access_unit_if.sv
// Request/response and memory-bus signal bundle for mem_access_unit.
// The master modport is the environment: the requester plus the memory.
// The slave modport is the access unit.
interface mem_access_unit_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic                  req_valid;
    logic                  req_instr;
    logic                  req_write;
    logic [2:0]            req_funct3;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  busy;
    logic                  resp_valid;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  resp_err;
    logic [ADDR_W-1:0]     bus_addr;
    logic                  bus_read;
    logic                  bus_write;
    logic [DATA_W/8-1:0]   bus_mask;
    logic [DATA_W-1:0]     bus_wdata;
    logic [DATA_W-1:0]     bus_rdata;
    logic                  bus_done;

    modport master (
        output req_valid, req_instr, req_write, req_funct3, req_addr, req_wdata,
        input  busy, resp_valid, resp_rdata, resp_err,
        input  bus_addr, bus_read, bus_write, bus_mask, bus_wdata,
        output bus_rdata, bus_done
    );

    modport slave (
        input  req_valid, req_instr, req_write, req_funct3, req_addr, req_wdata,
        output busy, resp_valid, resp_rdata, resp_err,
        output bus_addr, bus_read, bus_write, bus_mask, bus_wdata,
        input  bus_rdata, bus_done
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store/fetch unit: turns one RISC-V style access request into a single
// lane-aligned bus strobe, then returns the aligned and extended result.
module mem_access_unit #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input logic              clk,
    input logic              rst,
    mem_access_unit_if.slave mau
);
    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(MASK_W);
    localparam int unsigned CNT_W  = 16;
    // Last wait-counter value at which a missing bus_done ends the access.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [MASK_W-1:0] mask_q, mask_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;

    logic [1:0]        dec_size;
    logic              dec_uns;
    logic              dec_write;
    logic              dec_illegal;
    logic              dec_misal;
    logic [MASK_W-1:0] dec_mask;
    logic [OFF_W-1:0]  dec_off;

    logic [DATA_W-1:0] rd_shift;
    logic [DATA_W-1:0] rd_ext;

    // Decode the incoming request: size, signedness, legality and alignment.
    always_comb begin
        dec_size    = mau.req_funct3[1:0];
        dec_uns     = mau.req_funct3[2];
        dec_write   = mau.req_write;
        dec_illegal = 1'b0;
        dec_misal   = 1'b0;
        dec_mask    = '0;
        dec_off     = mau.req_addr[OFF_W-1:0];
        if (mau.req_instr) begin
            dec_size  = 2'b10;
            dec_uns   = 1'b1;
            dec_write = 1'b0;
        end else if (dec_write) begin
            dec_illegal = mau.req_funct3[2];
        end else begin
            // 110 (word, zero-extend) only exists on a 64-bit bus.
            dec_illegal = (mau.req_funct3 == 3'b111) ||
                          (DATA_W == 32 && mau.req_funct3 == 3'b110);
        end
        if (DATA_W == 32 && dec_size == 2'b11) begin
            dec_illegal = 1'b1;
        end
        case (dec_size)
            2'b00: begin
                dec_misal = 1'b0;
                dec_mask  = MASK_W'(8'h01);
            end
            2'b01: begin
                dec_misal = mau.req_addr[0];
                dec_mask  = MASK_W'(8'h03);
            end
            2'b10: begin
                dec_misal = |mau.req_addr[1:0];
                dec_mask  = MASK_W'(8'h0F);
            end
            default: begin
                dec_misal = |mau.req_addr[2:0];
                dec_mask  = MASK_W'(8'hFF);
            end
        endcase
    end

    // Move read data down to bit 0 and extend it to the full bus width.
    always_comb begin
        rd_shift = mau.bus_rdata >> {off_q, 3'b000};
        case (size_q)
            2'b00:   rd_ext = uns_q ? DATA_W'(rd_shift[7:0])
                                    : DATA_W'($signed(rd_shift[7:0]));
            2'b01:   rd_ext = uns_q ? DATA_W'(rd_shift[15:0])
                                    : DATA_W'($signed(rd_shift[15:0]));
            2'b10:   rd_ext = uns_q ? DATA_W'(rd_shift[31:0])
                                    : DATA_W'($signed(rd_shift[31:0]));
            default: rd_ext = rd_shift;
        endcase
    end

    // Next-state logic: accept, strobe until done or timeout, one-cycle response.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        off_d   = off_q;
        size_d  = size_q;
        uns_d   = uns_q;
        case (state_q)
            StIdle: begin
                if (mau.req_valid) begin
                    off_d  = dec_off;
                    size_d = dec_size;
                    uns_d  = dec_uns;
                    if (dec_illegal || dec_misal) begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        err_d   = 1'b0;
                        cnt_d   = '0;
                        addr_d  = {mau.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        mask_d  = dec_mask << dec_off;
                        wdata_d = mau.req_wdata << {dec_off, 3'b000};
                        state_d = dec_write ? StWrite : StRead;
                    end
                end
            end
            StRead, StWrite: begin
                if (mau.bus_done) begin
                    // A completion in the timeout cycle still counts as success.
                    rdata_d = (state_q == StWrite) ? '0 : rd_ext;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset also kills any strobe in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            mask_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            off_q   <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            off_q   <= off_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
        end
    end

    assign mau.busy       = (state_q != StIdle);
    assign mau.bus_read   = (state_q == StRead);
    assign mau.bus_write  = (state_q == StWrite);
    assign mau.resp_valid = (state_q == StResp);
    // Error flag is only meaningful alongside resp_valid.
    assign mau.resp_err   = (state_q == StResp) && err_q;
    assign mau.resp_rdata = rdata_q;
    assign mau.bus_addr   = addr_q;
    assign mau.bus_mask   = mask_q;
    assign mau.bus_wdata  = wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a 32-bit and a 64-bit instance receive the same
// request stream; each has its own bus responder and is checked against a
// byte-arithmetic reference model.
module tb_mem_access_unit;
    localparam int unsigned TMO = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid;
    logic        req_instr;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;

    mem_access_unit_if #(.DATA_W(32), .ADDR_W(32)) if32 ();
    mem_access_unit_if #(.DATA_W(64), .ADDR_W(32)) if64 ();

    assign if32.req_valid  = req_valid;
    assign if32.req_instr  = req_instr;
    assign if32.req_write  = req_write;
    assign if32.req_funct3 = req_funct3;
    assign if32.req_addr   = req_addr;
    assign if32.req_wdata  = req_wdata[31:0];
    assign if64.req_valid  = req_valid;
    assign if64.req_instr  = req_instr;
    assign if64.req_write  = req_write;
    assign if64.req_funct3 = req_funct3;
    assign if64.req_addr   = req_addr;
    assign if64.req_wdata  = req_wdata;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TMO)) dut32 (
        .clk (clk),
        .rst (rst),
        .mau (if32)
    );
    mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(TMO)) dut64 (
        .clk (clk),
        .rst (rst),
        .mau (if64)
    );

    int checks = 0;
    int errors = 0;

    // Responder configuration and strobe observations, index 0 = 32-bit, 1 = 64-bit.
    int          done_at[2]    = '{0, 0};
    logic [63:0] rd_val[2]     = '{64'd0, 64'd0};
    int          strobe_n[2]   = '{0, 0};
    logic [31:0] s_addr[2];
    logic [7:0]  s_mask[2];
    logic [63:0] s_wdata[2];
    logic        s_wr[2];
    logic        s_unstable[2] = '{1'b0, 1'b0};
    int          r_cnt[2];
    int          r_lat[2];
    logic        r_err[2];
    logic [63:0] r_rdata[2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic resp_step(input int d, input logic strb, input logic wr,
                             input logic [31:0] a, input logic [7:0] m, input logic [63:0] wdat,
                             output logic dn, output logic [63:0] rv);
        if (strb) begin
            strobe_n[d]++;
            if (strobe_n[d] == 1) begin
                s_addr[d]  = a;
                s_mask[d]  = m;
                s_wdata[d] = wdat;
                s_wr[d]    = wr;
            end else if (a !== s_addr[d] || m !== s_mask[d] || wdat !== s_wdata[d] ||
                         wr !== s_wr[d]) begin
                s_unstable[d] = 1'b1;
            end
            dn = (strobe_n[d] == done_at[d]);
            rv = dn ? rd_val[d] : {$urandom(), $urandom()};
        end else begin
            // Outside a strobe the bus lines carry junk the unit must ignore.
            dn = 1'($urandom_range(0, 1));
            rv = {$urandom(), $urandom()};
        end
    endtask

    initial begin
        logic        dn;
        logic [63:0] rv;
        if32.bus_done  = 1'b0;
        if32.bus_rdata = '0;
        forever begin
            @(negedge clk);
            resp_step(0, if32.bus_read | if32.bus_write, if32.bus_write, if32.bus_addr,
                      8'(if32.bus_mask), 64'(if32.bus_wdata), dn, rv);
            if32.bus_done  = dn;
            if32.bus_rdata = rv[31:0];
        end
    end

    initial begin
        logic        dn;
        logic [63:0] rv;
        if64.bus_done  = 1'b0;
        if64.bus_rdata = '0;
        forever begin
            @(negedge clk);
            resp_step(1, if64.bus_read | if64.bus_write, if64.bus_write, if64.bus_addr,
                      if64.bus_mask, if64.bus_wdata, dn, rv);
            if64.bus_done  = dn;
            if64.bus_rdata = rv;
        end
    end

    // Reference behaviour of one access on a w-bit bus, from byte arithmetic.
    function automatic void model(input int w, input logic instr, input logic wr_in,
                                  input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [63:0] wd, input logic [63:0] rd, input int dat,
                                  output logic e_err, output int e_lat, output int e_strb,
                                  output logic [31:0] e_addr, output logic [7:0] e_mask,
                                  output logic [63:0] e_wdata, output logic [63:0] e_rdata,
                                  output logic e_wr);
        int bytes;
        int off;
        logic uns;
        logic wr;
        logic bad;
        logic [127:0] wmask;
        logic [127:0] lim;
        logic [127:0] t;
        bytes = instr ? 4 : (1 << f3[1:0]);
        uns   = instr ? 1'b1 : f3[2];
        wr    = instr ? 1'b0 : wr_in;
        bad   = 1'b0;
        if (!instr) begin
            if (wr && f3[2]) bad = 1'b1;
            if (!wr && f3 == 3'd7) bad = 1'b1;
            if (w == 32 && bytes == 8) bad = 1'b1;
            if (w == 32 && !wr && f3 == 3'd6) bad = 1'b1;
        end
        if (int'(addr[2:0]) % bytes != 0) bad = 1'b1;
        off     = int'(addr[2:0]) % (w / 8);
        wmask   = (128'd1 << w) - 128'd1;
        e_wr    = wr;
        e_addr  = addr - 32'(off);
        e_mask  = 8'(((1 << bytes) - 1) << off);
        t       = ((128'(wd) & wmask) << (8 * off)) & wmask;
        e_wdata = 64'(t);
        lim     = (128'd1 << (8 * bytes)) - 128'd1;
        t       = ((128'(rd) & wmask) >> (8 * off)) & lim;
        if (!uns && t[8 * bytes - 1]) t = t | ~lim;
        e_rdata = wr ? 64'd0 : 64'(t & wmask);
        if (bad) begin
            e_err  = 1'b1;
            e_lat  = 1;
            e_strb = 0;
        end else if (dat <= int'(TMO)) begin
            e_err  = 1'b0;
            e_lat  = dat + 1;
            e_strb = dat;
        end else begin
            e_err  = 1'b1;
            e_lat  = int'(TMO) + 1;
            e_strb = int'(TMO);
        end
    endfunction

    task automatic sample_resp(input int k);
        if (if32.resp_valid === 1'b1) begin
            r_cnt[0]++;
            if (r_cnt[0] == 1) begin
                r_lat[0]   = k;
                r_err[0]   = if32.resp_err;
                r_rdata[0] = 64'(if32.resp_rdata);
            end
        end
        if (if64.resp_valid === 1'b1) begin
            r_cnt[1]++;
            if (r_cnt[1] == 1) begin
                r_lat[1]   = k;
                r_err[1]   = if64.resp_err;
                r_rdata[1] = if64.resp_rdata;
            end
        end
    endtask

    // One request to both units; bus_done arrives on strobe cycle d0 / d1.
    task automatic txn(input string nm, input logic instr, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [63:0] wd,
                       input logic [63:0] rd0, input logic [63:0] rd1, input int d0, input int d1);
        logic        e_err;
        int          e_lat;
        int          e_strb;
        logic [31:0] e_addr;
        logic [7:0]  e_mask;
        logic [63:0] e_wdata;
        logic [63:0] e_rdata;
        logic        e_wr;
        @(negedge clk);
        req_valid  = 1'b1;
        req_instr  = instr;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        done_at    = '{d0, d1};
        rd_val     = '{rd0, rd1};
        strobe_n   = '{0, 0};
        s_unstable = '{1'b0, 1'b0};
        r_cnt      = '{0, 0};
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            #1;
            sample_resp(k);
            if (k == 1) begin
                // Scramble the request lines: the unit must work from its latched copy.
                @(negedge clk);
                req_valid  = 1'b0;
                req_instr  = 1'($urandom_range(0, 1));
                req_write  = 1'($urandom_range(0, 1));
                req_funct3 = 3'($urandom_range(0, 7));
                req_addr   = $urandom();
                req_wdata  = {$urandom(), $urandom()};
            end
            @(posedge clk);
        end
        for (int d = 0; d < 2; d++) begin
            int w;
            w = (d == 0) ? 32 : 64;
            model(w, instr, wr, f3, addr, wd, (d == 0) ? rd0 : rd1, (d == 0) ? d0 : d1,
                  e_err, e_lat, e_strb, e_addr, e_mask, e_wdata, e_rdata, e_wr);
            check($sformatf("%s w%0d resp_count", nm, w), 64'(r_cnt[d]), 64'd1);
            check($sformatf("%s w%0d latency", nm, w), 64'(r_lat[d]), 64'(e_lat));
            check($sformatf("%s w%0d resp_err", nm, w), 64'(r_err[d]), 64'(e_err));
            check($sformatf("%s w%0d strobes", nm, w), 64'(strobe_n[d]), 64'(e_strb));
            if (e_strb > 0) begin
                check($sformatf("%s w%0d bus_addr", nm, w), 64'(s_addr[d]), 64'(e_addr));
                check($sformatf("%s w%0d bus_mask", nm, w), 64'(s_mask[d]), 64'(e_mask));
                check($sformatf("%s w%0d is_write", nm, w), 64'(s_wr[d]), 64'(e_wr));
                check($sformatf("%s w%0d stable", nm, w), 64'(s_unstable[d]), 64'd0);
                if (e_wr) begin
                    check($sformatf("%s w%0d bus_wdata", nm, w), s_wdata[d], e_wdata);
                end
            end
            if (!e_err) begin
                check($sformatf("%s w%0d rdata", nm, w), r_rdata[d], e_rdata);
            end
        end
    endtask

    initial begin
        logic        ins;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        int          bytes;
        int          seen;

        rst        = 1'b0;
        req_valid  = 1'b0;
        req_instr  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = '0;
        req_wdata  = '0;

        #2;
        check("rst busy32", 64'(if32.busy), 64'd0);
        check("rst resp_valid32", 64'(if32.resp_valid), 64'd0);
        check("rst resp_err32", 64'(if32.resp_err), 64'd0);
        check("rst strobes32", 64'({if32.bus_read, if32.bus_write}), 64'd0);
        check("rst bus_mask32", 64'(if32.bus_mask), 64'd0);
        check("rst bus_wdata32", 64'(if32.bus_wdata), 64'd0);
        check("rst bus_addr32", 64'(if32.bus_addr), 64'd0);
        check("rst resp_rdata32", 64'(if32.resp_rdata), 64'd0);
        check("rst busy64", 64'(if64.busy), 64'd0);
        check("rst strobes64", 64'({if64.bus_read, if64.bus_write}), 64'd0);
        check("rst bus_mask64", 64'(if64.bus_mask), 64'd0);
        check("rst resp_rdata64", if64.resp_rdata, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // LB at 0x1003, done on the first strobe cycle.
        txn("lb", 1'b0, 1'b0, 3'b000, 32'h0000_1003, 64'd0,
            64'h0000_0000_80AB_CDEF, 64'h1122_3344_5566_7788, 1, 1);
        check("lb const rdata32", r_rdata[0], 64'h0000_0000_FFFF_FF80);
        check("lb const mask32", 64'(s_mask[0]), 64'h08);
        check("lb const latency32", 64'(r_lat[0]), 64'd2);

        // SH at 0x2002, three wait cycles then done.
        txn("sh", 1'b0, 1'b1, 3'b001, 32'h0000_2002, 64'h0000_0000_0000_1234,
            64'd0, 64'd0, 4, 4);
        check("sh const wdata32", s_wdata[0], 64'h0000_0000_1234_0000);
        check("sh const mask32", 64'(s_mask[0]), 64'h0C);
        check("sh const strobes32", 64'(strobe_n[0]), 64'd4);

        // Misaligned LW: error straight away, no strobe.
        txn("lw_mis", 1'b0, 1'b0, 3'b010, 32'h0000_0006, 64'd0, 64'd0, 64'd0, 1, 1);
        check("lw_mis const latency32", 64'(r_lat[0]), 64'd1);

        // Fetch with no completion, then with completion exactly on the last cycle.
        txn("fetch_tmo", 1'b1, 1'b0, 3'b000, 32'h0000_0100, 64'd0, 64'd0, 64'd0, 99, 99);
        check("fetch_tmo const err32", 64'(r_err[0]), 64'd1);
        txn("fetch_edge", 1'b1, 1'b0, 3'b000, 32'h0000_0104, 64'd0,
            64'h0000_0000_DEAD_BEEF, 64'h0000_0000_DEAD_BEEF, 4, 4);
        check("fetch_edge const err32", 64'(r_err[0]), 64'd0);

        // LWU at an upper-word address on the wide bus.
        txn("lwu", 1'b0, 1'b0, 3'b110, 32'h0000_0804, 64'd0,
            64'h0000_0000_F000_0001, 64'hF000_0001_0000_0000, 1, 1);
        check("lwu const mask64", 64'(s_mask[1]), 64'hF0);
        check("lwu const rdata64", r_rdata[1], 64'h0000_0000_F000_0001);

        // Reset in the middle of a store wait.
        @(negedge clk);
        req_valid  = 1'b1;
        req_instr  = 1'b0;
        req_write  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_0040;
        req_wdata  = 64'h0000_0000_CAFE_F00D;
        done_at    = '{99, 99};
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid bus_write32", 64'(if32.bus_write), 64'd1);
        rst = 1'b0;
        #1;
        check("arst bus_write32", 64'(if32.bus_write), 64'd0);
        check("arst bus_write64", 64'(if64.bus_write), 64'd0);
        check("arst busy32", 64'(if32.busy), 64'd0);
        check("arst bus_mask64", 64'(if64.bus_mask), 64'd0);
        @(negedge clk);
        rst  = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (if32.resp_valid === 1'b1 || if64.resp_valid === 1'b1) seen++;
        end
        check("arst no_resp", 64'(seen), 64'd0);
        txn("after_rst", 1'b0, 1'b1, 3'b010, 32'h0000_0048, 64'h0000_0000_0BAD_CAFE,
            64'd0, 64'd0, 2, 2);

        // Randomized accesses, biased towards aligned addresses.
        for (int i = 0; i < 80; i++) begin
            ins   = ($urandom_range(0, 7) == 0);
            wr    = 1'($urandom_range(0, 1));
            f3    = 3'($urandom_range(0, 7));
            a     = $urandom();
            bytes = ins ? 4 : (1 << f3[1:0]);
            if ($urandom_range(0, 3) != 0) a = a & ~32'(bytes - 1);
            txn($sformatf("rnd%0d", i), ins, wr, f3, a, {$urandom(), $urandom()},
                {$urandom(), $urandom()}, {$urandom(), $urandom()},
                $urandom_range(1, 6), $urandom_range(1, 6));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DATA_W, default 32, meaning bus data width in bits; legal values 32 and 64.
REQ-002 Parameter ADDR_W, default 32, meaning byte-address width.
REQ-003 Parameter TIMEOUT, default 255, meaning maximum wait cycles per bus access; legal range 1 to 65535.
REQ-004 clk  in  1  single clock; all registers on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  1  access request; held by requester until accepted.
REQ-007 req_instr  in  1  1 = instruction fetch of 32 bits; overrides req_write and req_funct3.
REQ-008 req_write  in  1  1 = store, 0 = load.
REQ-009 req_funct3  in  3  RISC-V load/store size and sign code.
REQ-010 req_addr  in  ADDR_W  byte address.
REQ-011 req_wdata  in  DATA_W  store data, right-aligned.
REQ-012 busy  out  1  1 = request not acceptable this cycle.
REQ-013 resp_valid  out  1  one-cycle completion pulse.
REQ-014 resp_rdata  out  DATA_W  load/fetch data, right-aligned and extended.
REQ-015 resp_err  out  1  qualifies resp_valid; 1 = misaligned, illegal code or timeout.
REQ-016 bus_addr  out  ADDR_W  lane-aligned address; low log2(DATA_W/8) bits are 0.
REQ-017 bus_read, bus_write  out  1 each  bus strobes.
REQ-018 bus_mask  out  DATA_W/8  byte-lane enables.
REQ-019 bus_wdata  out  DATA_W  lane-shifted store data.
REQ-020 bus_rdata  in  DATA_W  bus read data; valid when bus_done=1.
REQ-021 bus_done  in  1  bus completion for the current strobe.

Function
REQ-022 FSM states: IDLE, READ, WRITE, RESP; busy=0 only in IDLE.
REQ-023 IDLE with req_valid=1 latches all req_* fields; legal load or fetch -> READ, legal store -> WRITE, illegal -> RESP with error set.
REQ-024 Access size from funct3[1:0]: 00 byte, 01 half, 10 word, 11 double; double is legal only when DATA_W=64.
REQ-025 Loads: funct3[2]=1 selects zero-extend; 111 is illegal; 110 is illegal when DATA_W=32.
REQ-026 Stores: funct3[2]=1 is illegal.
REQ-027 A fetch is always word size with zero-extend.
REQ-028 Misaligned: address not a multiple of the access size -> error, no bus strobe issued.
REQ-029 bus_mask = size mask shifted left by the byte offset; bus_wdata = req_wdata shifted left by 8 x offset.
REQ-030 READ or WRITE holds its strobe and registered address, mask and data constant until bus_done=1 or timeout.
REQ-031 Strobe cycle with bus_done=1: capture the result (shifted down by offset, sign- or zero-extended to DATA_W for loads, 0 for stores) and go to RESP; strobe drops next cycle.
REQ-032 Wait counter clears on entry to READ or WRITE and increments each cycle with bus_done=0.
REQ-033 Timeout when the counter reaches TIMEOUT: drop the strobe, set error, go to RESP; bus_done arriving in that same cycle takes priority over timeout (success).
REQ-034 RESP lasts one cycle: resp_valid=1 with resp_err, then IDLE; resp_rdata holds its value until the next response.
REQ-035 Acceptance latency: a request accepted at edge N produces a strobe in cycle N+1; the earliest response is in cycle N+2 (bus_done in the first strobe cycle); an error response without a bus access occurs in cycle N+1.
REQ-036 req_valid while busy=1 is ignored; back-to-back accepts are possible every 3 cycles minimum.
REQ-037 bus_done in IDLE or RESP is ignored.

Reset
REQ-038 While rst=0 (asynchronous): state IDLE; busy, resp_valid, resp_err, bus_read, bus_write = 0; bus_mask, bus_wdata, bus_addr, resp_rdata, counter = 0.
REQ-039 Reset asserted mid-access drops the strobe immediately and produces no response; operation resumes on the first edge after release.

Verification
REQ-040 DATA_W=32, LB at 0x1003, bus_rdata=0x80AB_CDEF, done on 1st strobe cycle -> bus_mask=1000, resp_rdata=0xFFFF_FF80, resp_err=0, resp 2 cycles after accept.
REQ-041 DATA_W=32, SH at 0x2002, req_wdata=0x0000_1234, done after 3 waits -> bus_mask=1100, bus_wdata=0x1234_0000, strobe 4 cycles, resp_err=0.
REQ-042 LW at 0x0006 -> no strobe, resp_valid with resp_err=1 in the cycle after accept.
REQ-043 TIMEOUT=4, fetch, bus_done never asserted -> bus_read high 4 cycles then low, resp_err=1; done exactly on the 4th cycle -> resp_err=0.
REQ-044 DATA_W=64, LWU at 0x...04, bus_rdata=0xF000_0001_0000_0000 -> bus_mask=0xF0, resp_rdata=0x0000_0000_F000_0001.
REQ-045 rst pulsed low during WRITE wait -> bus_write=0 asynchronously, no resp_valid; a new request after release completes normally.
